// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial ripple adder, LSB first, one result per WIDTH+2 cycles
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_hs1_sum;
  logic             w_hs1_carry;
  logic             w_hs2_carry;
  logic             w_bit;
  logic             w_carry;
  logic [WIDTH-1:0] w_res_next;

  // Full adder as two cascaded half adders with their carries ORed.
  assign w_hs1_sum   = r_a[0] ^ r_b[0];
  assign w_hs1_carry = r_a[0] & r_b[0];
  assign w_bit       = w_hs1_sum ^ r_carry;
  assign w_hs2_carry = w_hs1_sum & r_carry;
  assign w_carry     = w_hs1_carry | w_hs2_carry;
  assign w_res_next  = {w_bit, r_res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_ADD;
      S_ADD:   if (r_cnt == LAST) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        S_ADD: begin
          r_res   <= w_res_next;
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_carry <= w_carry;
          r_cnt   <= r_cnt + 1'b1;
          // Final bit goes straight to the output so sum lands on the ADD->DONE edge.
          if (r_cnt == LAST) begin
            r_sum  <= w_res_next;
            r_cout <= w_carry;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == S_ADD);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
